// File: rtl/muldiv_pkg.sv
// Shared MUL/DIV definitions: width, op-code values and sequencer states.
package muldiv_pkg;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MFHI  = 3'b100;
   localparam logic [2:0] OP_MFLO  = 3'b101;
   localparam logic [2:0] OP_MTHI  = 3'b110;
   localparam logic [2:0] OP_MTLO  = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2
   } state_e;

   function automatic logic is_iter(input logic [2:0] op);
      return ~op[2];
   endfunction

endpackage

// File: rtl/muldiv_core.sv
// Iterative datapath: shift-add multiply / restoring divide on magnitudes.
// Both modes leave the upper word in o_hi and the lower word in o_lo.
module muldiv_core #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_div,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo,
   output logic            o_last
);

   localparam int CW = $clog2(XLEN);

   logic [XLEN:0]   r_acc;
   logic [XLEN-1:0] r_shf;
   logic [XLEN-1:0] r_opd;
   logic [CW-1:0]   r_cnt;
   logic            r_div;

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_rem;
   logic [XLEN:0]   w_diff;
   logic [XLEN:0]   w_acc_n;
   logic [XLEN-1:0] w_shf_n;

   assign w_sum  = r_acc + {1'b0, (r_shf[0] ? r_opd : '0)};
   assign w_rem  = {r_acc[XLEN-1:0], r_shf[XLEN-1]};
   assign w_diff = w_rem - {1'b0, r_opd};

   always_comb begin
      w_acc_n = r_acc;
      w_shf_n = r_shf;
      if (r_div) begin
         // Negative trial difference means restore the shifted remainder
         if (w_diff[XLEN]) begin
            w_acc_n = w_rem;
            w_shf_n = {r_shf[XLEN-2:0], 1'b0};
         end else begin
            w_acc_n = w_diff;
            w_shf_n = {r_shf[XLEN-2:0], 1'b1};
         end
      end else begin
         w_acc_n = {1'b0, w_sum[XLEN:1]};
         w_shf_n = {w_sum[0], r_shf[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_shf <= '0;
         r_opd <= '0;
         r_cnt <= '0;
         r_div <= 1'b0;
      end else if (i_load) begin
         r_acc <= '0;
         r_shf <= i_a;
         r_opd <= i_b;
         r_cnt <= '0;
         r_div <= i_div;
      end else if (i_step) begin
         r_acc <= w_acc_n;
         r_shf <= w_shf_n;
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_hi   = r_acc[XLEN-1:0];
   assign o_lo   = r_shf;
   assign o_last = (r_cnt == CW'(XLEN - 1));

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO unit: sequencing FSM, sign fix-up, HI/LO registers and EX stall/forwarding.
module muldiv_sequencer #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   input  logic [2:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            stall,
   output logic [XLEN-1:0] rd_data,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
);

   import muldiv_pkg::*;

   state_e          r_state;
   state_e          w_next;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_araw;
   logic            r_negq;
   logic            r_negr;
   logic            r_dz;
   logic            r_div;

   logic            w_idle;
   logic            w_accept;
   logic            w_signed;
   logic            w_sa;
   logic            w_sb;
   logic            w_bz;
   logic            w_mthi;
   logic            w_mtlo;
   logic            w_mfhi;
   logic            w_mflo;
   logic            w_last;
   logic [XLEN-1:0] w_ma;
   logic [XLEN-1:0] w_mb;
   logic [XLEN-1:0] w_core_hi;
   logic [XLEN-1:0] w_core_lo;
   logic [XLEN-1:0] w_fix_hi;
   logic [XLEN-1:0] w_fix_lo;
   logic [2*XLEN-1:0] w_prod;

   assign w_idle   = (r_state == S_IDLE);
   assign w_accept = req_valid & w_idle & is_iter(req_op);
   assign w_signed = (req_op == OP_MULT) | (req_op == OP_DIV);
   assign w_sa     = w_signed & req_a[XLEN-1];
   assign w_sb     = w_signed & req_b[XLEN-1];
   assign w_ma     = w_sa ? -req_a : req_a;
   assign w_mb     = w_sb ? -req_b : req_b;
   assign w_bz     = req_op[1] & (req_b == '0);
   assign w_mthi   = req_valid & w_idle & (req_op == OP_MTHI);
   assign w_mtlo   = req_valid & w_idle & (req_op == OP_MTLO);
   assign w_mfhi   = req_valid & w_idle & (req_op == OP_MFHI);
   assign w_mflo   = req_valid & w_idle & (req_op == OP_MFLO);

   muldiv_core #(
      .XLEN (XLEN)
   ) u_core (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_load (w_accept),
      .i_step (r_state == S_RUN),
      .i_div  (req_op[1]),
      .i_a    (w_ma),
      .i_b    (w_mb),
      .o_hi   (w_core_hi),
      .o_lo   (w_core_lo),
      .o_last (w_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_accept) w_next = w_bz ? S_FIX : S_RUN;
         S_RUN:   if (w_last) w_next = S_FIX;
         S_FIX:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = !w_idle;
      done    = (r_state == S_FIX);
      stall   = req_valid & !w_idle;
      rd_data = '0;
      unique case (1'b1)
         w_mfhi:  rd_data = r_hi;
         w_mflo:  rd_data = r_lo;
         default: rd_data = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_araw <= '0;
         r_negq <= 1'b0;
         r_negr <= 1'b0;
         r_dz   <= 1'b0;
         r_div  <= 1'b0;
      end else if (w_accept) begin
         r_araw <= req_a;
         r_negq <= w_sa ^ w_sb;
         r_negr <= w_sa;
         r_dz   <= w_bz;
         r_div  <= req_op[1];
      end
   end

   assign w_prod = {w_core_hi, w_core_lo};

   always_comb begin
      w_fix_hi = w_core_hi;
      w_fix_lo = w_core_lo;
      if (r_dz) begin
         w_fix_hi = r_araw;
         w_fix_lo = '1;
      end else if (r_div) begin
         // Remainder follows dividend sign; quotient truncates toward zero
         w_fix_hi = r_negr ? -w_core_hi : w_core_hi;
         w_fix_lo = r_negq ? -w_core_lo : w_core_lo;
      end else begin
         {w_fix_hi, w_fix_lo} = r_negq ? -w_prod : w_prod;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else if (r_state == S_FIX) begin
         r_hi <= w_fix_hi;
         r_lo <= w_fix_lo;
      end else if (w_mthi) begin
         r_hi <= req_a;
      end else if (w_mtlo) begin
         r_lo <= req_a;
      end
   end

   assign hi = r_hi;
   assign lo = r_lo;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [2:0]  req_op = 3'd0;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] rd_data;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_tests = 0;
   int n_fail  = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   muldiv_sequencer #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .stall     (stall),
      .rd_data   (rd_data),
      .busy      (busy),
      .done      (done),
      .hi        (hi),
      .lo        (lo)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] ref_res(input logic [2:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = '0;
      case (op)
         3'b000: p = sa * sb;
         3'b001: p = {32'b0, a} * {32'b0, b};
         3'b010: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = sa / sb;
               r = sa % sb;
               p = {r[31:0], q[31:0]};
            end
         end
         3'b011: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   // Called at a negedge+; returns at negedge+1 of the first cycle after accept.
   task automatic issue(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      #1 chk("accept_stall", stall, 0);
      @(posedge clk);
      {m_hi, m_lo} = ref_res(op, a, b);
      @(negedge clk);
      req_valid = 1'b0;
      #1 chk("busy_after_accept", busy, 1);
   endtask

   task automatic finish_op(input int n0, input int exp_n);
      int n;
      n = n0;
      while (!done && n < 40) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("done_cycle", n, exp_n);
      @(negedge clk);
      #1;
      chk("done_pulse_end", done, 0);
      chk("busy_end", busy, 0);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
   endtask

   initial begin
      int n;
      logic [2:0]  op;
      logic [31:0] a, b;

      req_valid = 1'b1;
      req_op    = 3'b100;
      #2;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stall", stall, 0);
      chk("rst_rd_data", rd_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      req_valid = 1'b0;

      issue(3'b000, 32'd7, 32'hFFFF_FFFD);
      finish_op(1, 33);
      chk("mult_hi_const", hi, 32'hFFFF_FFFF);
      chk("mult_lo_const", lo, 32'hFFFF_FFEB);

      issue(3'b011, 32'd100, 32'd7);
      finish_op(1, 33);
      chk("divu_lo_const", lo, 32'd14);
      chk("divu_hi_const", hi, 32'd2);

      issue(3'b010, 32'hFFFF_FFF9, 32'd2);
      finish_op(1, 33);
      chk("div_lo_const", lo, 32'hFFFF_FFFD);
      chk("div_hi_const", hi, 32'hFFFF_FFFF);

      issue(3'b010, 32'd5, 32'd0);
      finish_op(1, 1);
      chk("dz_hi_const", hi, 32'd5);
      chk("dz_lo_const", lo, 32'hFFFF_FFFF);

      issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op(1, 33);
      chk("ovf_lo_const", lo, 32'h8000_0000);
      chk("ovf_hi_const", hi, 32'd0);

      // MFLO waits out the whole multiply
      issue(3'b000, $urandom, $urandom);
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 3'b101;
      #1;
      n = 0;
      while (stall && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
      chk("mflo_stall_cycles", n, 32);
      chk("mflo_stall_clear", stall, 0);
      chk("mflo_fwd", rd_data, m_lo);
      req_valid = 1'b0;

      // MTHI while busy must be stalled and ignored
      issue(3'b001, $urandom, $urandom);
      req_valid = 1'b1;
      req_op    = 3'b110;
      req_a     = 32'hDEAD_BEEF;
      #1 chk("busy_mt_stall", stall, 1);
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      finish_op(2, 33);

      @(negedge clk);
      req_valid = 1'b1;
      req_op    = 3'b110;
      req_a     = 32'd16;
      #1;
      chk("mthi_stall", stall, 0);
      chk("mthi_rd_zero", rd_data, 0);
      @(posedge clk);
      m_hi = 32'd16;
      @(negedge clk);
      req_op = 3'b100;
      #1;
      chk("mfhi_after_mthi", rd_data, 32'd16);
      chk("mfhi_stall", stall, 0);
      @(negedge clk);
      req_op = 3'b111;
      req_a  = 32'd0;
      @(posedge clk);
      m_lo = 32'd0;
      @(negedge clk);
      req_valid = 1'b0;
      #1;
      chk("mtlo_lo", lo, 0);
      chk("mthi_hi_kept", hi, 32'd16);
      chk("idle_rd_zero", rd_data, 0);

      for (int i = 0; i < 24; i++) begin
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         if ($urandom_range(0, 1) == 1) b = b >> $urandom_range(16, 31);
         if ($urandom_range(0, 7) == 0) b = '0;
         issue(op, a, b);
         finish_op(1, (op[1] && b == 0) ? 1 : 33);
      end

      // Asynchronous reset in the middle of a multiply
      issue(3'b001, $urandom, $urandom);
      repeat (9) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      m_hi = '0;
      m_lo = '0;
      chk("arst_busy", busy, 0);
      chk("arst_done", done, 0);
      chk("arst_hi", hi, 0);
      chk("arst_lo", lo, 0);
      @(negedge clk);
      rst_n = 1'b1;
      issue(3'b001, 32'd3, 32'd4);
      finish_op(1, 33);
      chk("post_rst_lo", lo, 32'd12);
      chk("post_rst_hi", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter XLEN, default 32, operand/HI/LO width; only 32 is supported.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  input  1  EX-stage request present this cycle.
REQ-005 req_op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MFHI, 101 MFLO, 110 MTHI, 111 MTLO.
REQ-006 req_a  input  XLEN  rs operand (multiplicand / dividend / MT* source).
REQ-007 req_b  input  XLEN  rt operand (multiplier / divisor).
REQ-008 stall  output  1  hold EX stage; request not accepted this cycle.
REQ-009 rd_data  output  XLEN  MFHI/MFLO result to EX writeback path.
REQ-010 busy  output  1  iterative operation in progress.
REQ-011 done  output  1  one-cycle pulse, final HI/LO write cycle.
REQ-012 hi, lo  output  XLEN  architectural HI/LO registers (debug/bench visibility).

Function
REQ-013 FSM states: IDLE, RUN, FIX; busy = (state != IDLE).
REQ-014 IDLE + req_valid + op MULT/MULTU/DIV/DIVU: latch operands (magnitudes for signed ops, plus result-sign flags), clear iteration counter, go to RUN; stall=0 in accept cycle.
REQ-015 RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle; exactly XLEN cycles, then FIX.
REQ-016 FIX: apply sign correction, write HI/LO, done=1, return to IDLE; HI/LO new values visible XLEN+1 cycles after accept edge.
REQ-017 MULT/MULTU: {hi,lo} = full 2*XLEN-bit product, signed or unsigned.
REQ-018 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-019 Divisor zero: skip RUN (IDLE->FIX directly), hi = req_a, lo = all ones; done still pulses.
REQ-020 DIV of 0x80000000 by 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-021 MFHI/MFLO in IDLE: rd_data = hi/lo combinationally, stall=0; in RUN/FIX: stall=1 until state returns to IDLE.
REQ-022 MTHI/MTLO in IDLE: write hi/lo from req_a at the edge; rd_data same cycle returns old value.
REQ-023 Any req_valid while busy: stall=1, no state change from the request; request re-presented by pipeline.
REQ-024 stall=0 whenever req_valid=0; rd_data = 0 when no MF* op presented.
REQ-025 Request in the cycle state returns to IDLE (after FIX) is accepted normally; no extra bubble.

Reset
REQ-026 rst_n low: state IDLE, hi=0, lo=0, counter=0, busy=0, done=0, stall=0 (req_valid permitting), immediately and independently of clk.
REQ-027 Reset during RUN/FIX aborts operation; no partial HI/LO write survives.
REQ-028 First request accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 Shared package muldiv_pkg holds XLEN, op-code constants and FSM state encoding; MIPS decode and this block both import it.
REQ-030 One sub-module, muldiv_core: iteration datapath (accumulator, partial remainder, shift registers, counter); muldiv_sequencer holds FSM, HI/LO, stall/forwarding logic.

Verification
REQ-031 MULT a=7 b=0xFFFFFFFD -> after 33 cycles hi=0xFFFFFFFF lo=0xFFFFFFEB, done one cycle.
REQ-032 DIVU a=100 b=7 -> lo=14 hi=2; DIV a=0xFFFFFFF9 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-033 MFLO presented 1 cycle after MULT accept -> stall=1 for 32 consecutive cycles, then rd_data=lo result, stall=0.
REQ-034 DIV a=5 b=0 -> next cycle done=1, hi=5 lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-035 MTHI a=16 then MFHI -> rd_data=16; MTLO a=0 -> lo=0.
REQ-036 rst_n low at RUN cycle 10 of MULTU -> busy=0, hi=lo=0 without clk edge; subsequent MULTU 3*4 -> lo=12 hi=0.
